mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_array.sv | 39 +++
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder slice.
package mem_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned CntWidth  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/mem_array.sv
// DEPTH x 32 storage: synchronous write port, registered read port.
// Contents are never reset; only the read register is.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [$clog2(DEPTH)-1:0]     waddr,
    input  logic [DataWidth-1:0]         wdata,
    input  logic                         re,
    input  logic                         rzero,
    input  logic [$clog2(DEPTH)-1:0]     raddr,
    output logic [DataWidth-1:0]         rdata
);

    logic [DataWidth-1:0] mem_q [DEPTH];
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // rzero forces a zero response for rejected (out-of-range / misaligned) loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= rzero ? '0 : mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-ported memory responder with WAIT_CYCLES wait states per access.
// Optional misaligned-access error output: define MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [31:0]          addr,
    input  logic [DataWidth-1:0] wdata,
    output logic                 ready,
    output logic                 ack,
    output logic [DataWidth-1:0] rdata
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    ,
    output logic                 err
`endif
);

    localparam int unsigned AddrWidth = $clog2(DEPTH);
    localparam logic [CntWidth-1:0] WaitInit =
        CntWidth'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 we_q;
    logic [31:0]          addr_q;
    logic [DataWidth-1:0] wdata_q;

    logic                 accept;
    logic                 enter_resp;
    logic                 acc_we;
    logic [31:0]          acc_addr;
    logic [DataWidth-1:0] acc_wdata;
    logic                 acc_ok;

    assign accept = (state_q == StIdle) && req;

    // With zero wait states the array is accessed on the accept edge, so use live inputs.
    assign acc_we    = (state_q == StIdle) ? we    : we_q;
    assign acc_addr  = (state_q == StIdle) ? addr  : addr_q;
    assign acc_wdata = (state_q == StIdle) ? wdata : wdata_q;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign acc_ok = (acc_addr[31:AddrWidth+2] == '0) && (acc_addr[1:0] == 2'b00);
    assign err    = (state_q == StResp) && (addr_q[1:0] != 2'b00);
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^acc_addr[1:0];
    assign acc_ok = (acc_addr[31:AddrWidth+2] == '0);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    assign ready = (state_q == StIdle);
    assign ack   = (state_q == StResp);

    mem_array #(
        .DEPTH(DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .rst   (rst),
        .we    (enter_resp && acc_we && acc_ok),
        .waddr (acc_addr[AddrWidth+1:2]),
        .wdata (acc_wdata),
        .re    (enter_resp && !acc_we),
        .rzero (!acc_ok),
        .raddr (acc_addr[AddrWidth+1:2]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder against a word-array reference model.
module tb_mem_responder;

    localparam int unsigned Depth = 64;
    localparam int unsigned Wait  = 2;
    localparam int unsigned Aw    = $clog2(Depth);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        req_z = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, ack, ready_z, ack_z;
    logic [31:0] rdata, rdata_z;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    logic        err, err_z;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem_m [Depth];
    logic [31:0] last_rd = '0;

    typedef struct {
        bit          w;
        logic [31:0] exp;
    } pend_t;

    always #5 clk = ~clk;

    mem_responder #(
        .DEPTH(Depth),
        .WAIT_CYCLES(Wait)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ready (ready),
        .ack   (ack),
        .rdata (rdata)
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        ,
        .err   (err)
`endif
    );

    mem_responder #(
        .DEPTH(Depth),
        .WAIT_CYCLES(0)
    ) dut_z (
        .clk   (clk),
        .rst   (rst),
        .req   (req_z),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ready (ready_z),
        .ack   (ack_z),
        .rdata (rdata_z)
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        ,
        .err   (err_z)
`endif
    );

    function automatic bit addr_ok(input logic [31:0] a);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        return (a < 32'(4 * Depth)) && (a[1:0] == 2'b00);
`else
        return a < 32'(4 * Depth);
`endif
    endfunction

    // Applies an access to the model; returns the data a load should see.
    function automatic logic [31:0] model_access(input bit w, input logic [31:0] a,
                                                 input logic [31:0] d);
        if (!addr_ok(a)) return 32'h0;
        if (w) begin
            mem_m[a[Aw+1:2]] = d;
            return 32'h0;
        end
        return mem_m[a[Aw+1:2]];
    endfunction

    // Drives one request; call right after a negedge. Returns at the ack-cycle negedge.
    task automatic access(input bit zw, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output bit busy_ok,
                          output bit e);
        int n = 0;
        while (!(zw ? ready_z : ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        we = w;
        addr = a;
        wdata = d;
        if (zw) req_z = 1'b1;
        else req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        req_z = 1'b0;
        we = 1'($urandom);
        addr = $urandom;
        wdata = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        e = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (zw ? ready_z : ready) busy_ok = 1'b0;
        end while (!(zw ? ack_z : ack) && lat < 20);
        rd = zw ? rdata_z : rdata;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        e = zw ? err_z : err;
`endif
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || ack !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: ready=%b ack=%b rdata=%h, required ready=1 ack=0 rdata=0",
                     ready, ack, rdata);
        end
        checks++;
        if (ready_z !== 1'b1 || ack_z !== 1'b0 || rdata_z !== 32'h0) begin
            failures++;
            $display("FAIL reset_state_z: ready=%b ack=%b rdata=%h, required 1/0/0",
                     ready_z, ack_z, rdata_z);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [31:0] rd, d;
        int lat, bad;
        bit bo, e;
        bad = 0;
        for (int i = 0; i < int'(Depth); i++) begin
            d = $urandom;
            void'(model_access(1'b1, 32'(i * 4), d));
            access(1'b0, 1'b1, 32'(i * 4), d, rd, lat, bo, e);
            if (lat != int'(Wait) + 1 || !bo) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL fill_latency: %0d stores with bad latency/ready, required 0", bad);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        int lat;
        bit bo, e;
        void'(model_access(1'b1, 32'h10, 32'hDEADBEEF));
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd, lat, bo, e);
        checks++;
        if (lat != 3 || !bo) begin
            failures++;
            $display("FAIL store_latency: lat=%0d busy_ok=%b, required lat=3 busy_ok=1", lat, bo);
        end
        access(1'b0, 1'b0, 32'h10, 32'h0, rd, lat, bo, e);
        checks++;
        if (lat != 3 || rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL store_load: lat=%0d rdata=%h, required lat=3 rdata=deadbeef", lat, rd);
        end
        last_rd = 32'hDEADBEEF;
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, exp;
        int lat, r, bad_lat, bad_data, bad_err;
        bit w, bo, e;
        bad_lat = 0;
        bad_data = 0;
        bad_err = 0;
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7) a = $urandom_range(0, 4 * Depth - 1);
            else if (r < 9) a = $urandom_range(4 * Depth, 16 * Depth);
            else a = $urandom;
            d = $urandom;
            exp = model_access(w, a, d);
            if (!w) begin
                last_rd = exp;
            end
            access(1'b0, w, a, d, rd, lat, bo, e);
            if (lat != int'(Wait) + 1 || !bo) bad_lat++;
            if (rd !== last_rd) begin
                bad_data++;
                $display("FAIL random_data: op=%0d we=%b addr=%h rdata=%h, required %h",
                         i, w, a, rd, last_rd);
            end
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
            if (e !== (a[1:0] != 2'b00)) bad_err++;
`endif
        end
        checks++;
        if (bad_lat != 0) begin
            failures++;
            $display("FAIL random_latency: %0d accesses off, required 0", bad_lat);
        end
        checks++;
        if (bad_data != 0) begin
            failures++;
            $display("FAIL random_data_total: %0d wrong responses, required 0", bad_data);
        end
        checks++;
        if (bad_err != 0) begin
            failures++;
            $display("FAIL random_err: %0d wrong err flags, required 0", bad_err);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        int lat;
        bit bo, e;
        access(1'b0, 1'b1, 32'h100, 32'h12345678, rd, lat, bo, e);
        checks++;
        if (lat != int'(Wait) + 1) begin
            failures++;
            $display("FAIL oor_store_ack: lat=%0d, required %0d", lat, Wait + 1);
        end
        access(1'b0, 1'b0, 32'h100, 32'h0, rd, lat, bo, e);
        checks++;
        if (lat != int'(Wait) + 1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL oor_load: lat=%0d rdata=%h, required lat=%0d rdata=0", lat, rd, Wait + 1);
        end
        access(1'b0, 1'b0, 32'h0, 32'h0, rd, lat, bo, e);
        checks++;
        if (rd !== mem_m[0]) begin
            failures++;
            $display("FAIL oor_word0: rdata=%h, required %h", rd, mem_m[0]);
        end
        last_rd = mem_m[0];
    endtask

    task automatic test_back_to_back();
        localparam int N = 12;
        bit          ow [N];
        logic [31:0] oa [N];
        logic [31:0] od [N];
        pend_t       pend_q [$];
        pend_t       p;
        int          acc_cyc [$];
        int          k, ack_cnt, bad_gap;
        for (int i = 0; i < N; i++) begin
            ow[i] = (i < N / 2);
            oa[i] = (i < N / 2) ? 32'($urandom_range(0, Depth - 1) * 4) : oa[i - N / 2];
            od[i] = $urandom;
        end
        while (!ready) @(negedge clk);
        k = 0;
        ack_cnt = 0;
        we = ow[0];
        addr = oa[0];
        wdata = od[0];
        req = 1'b1;
        for (int cyc = 0; cyc < N * (int'(Wait) + 2) + 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (ack) begin
                ack_cnt++;
                checks++;
                if (pend_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra_ack: ack with nothing pending at cycle %0d", cyc);
                end else begin
                    p = pend_q.pop_front();
                    if (rdata !== p.exp) begin
                        failures++;
                        $display("FAIL b2b_data: we=%b rdata=%h, required %h", p.w, rdata, p.exp);
                    end
                end
            end
            if (ready && k < N) begin
                p.w = ow[k];
                p.exp = model_access(ow[k], oa[k], od[k]);
                if (ow[k]) p.exp = last_rd;
                else last_rd = p.exp;
                pend_q.push_back(p);
                acc_cyc.push_back(cyc);
                @(posedge clk);
                #1;
                k++;
                if (k < N) begin
                    we = ow[k];
                    addr = oa[k];
                    wdata = od[k];
                end else begin
                    req = 1'b0;
                end
            end
        end
        req = 1'b0;
        checks++;
        if (ack_cnt != N || k != N) begin
            failures++;
            $display("FAIL b2b_count: acks=%0d accepted=%0d, required %0d each", ack_cnt, k, N);
        end
        bad_gap = 0;
        for (int i = 1; i < acc_cyc.size(); i++) begin
            if (acc_cyc[i] - acc_cyc[i - 1] != int'(Wait) + 2) bad_gap++;
        end
        checks++;
        if (bad_gap != 0) begin
            failures++;
            $display("FAIL b2b_spacing: %0d irregular gaps, required 0", bad_gap);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, old;
        int lat, stray;
        bit bo, e;
        old = mem_m[8];
        @(negedge clk);
        while (!ready) @(negedge clk);
        we = 1'b1;
        addr = 32'h20;
        wdata = ~old;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || ack !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_state: ready=%b ack=%b rdata=%h, required 1/0/0",
                     ready, ack, rdata);
        end
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack !== 1'b0) stray++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ack !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL reset_mid_ack: %0d stray acks, required 0", stray);
        end
        last_rd = 32'h0;
        access(1'b0, 1'b0, 32'h20, 32'h0, rd, lat, bo, e);
        checks++;
        if (rd !== old) begin
            failures++;
            $display("FAIL reset_mid_data: rdata=%h, required %h", rd, old);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd, d;
        int lat;
        bit bo, e;
        d = $urandom;
        @(negedge clk);
        access(1'b1, 1'b1, 32'h04, d, rd, lat, bo, e);
        checks++;
        if (lat != 1 || !bo) begin
            failures++;
            $display("FAIL zw_store: lat=%0d busy_ok=%b, required lat=1 busy_ok=1", lat, bo);
        end
        access(1'b1, 1'b0, 32'h04, 32'h0, rd, lat, bo, e);
        checks++;
        if (lat != 1 || rd !== d) begin
            failures++;
            $display("FAIL zw_load: lat=%0d rdata=%h, required lat=1 rdata=%h", lat, rd, d);
        end
    endtask

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    task automatic test_align();
        logic [31:0] rd;
        int lat;
        bit bo, e;
        access(1'b0, 1'b1, 32'h13, 32'hA5A5A5A5, rd, lat, bo, e);
        checks++;
        if (e !== 1'b1 || lat != int'(Wait) + 1) begin
            failures++;
            $display("FAIL align_err: err=%b lat=%0d, required err=1 lat=%0d", e, lat, Wait + 1);
        end
        access(1'b0, 1'b0, 32'h10, 32'h0, rd, lat, bo, e);
        checks++;
        if (rd !== mem_m[4] || e !== 1'b0) begin
            failures++;
            $display("FAIL align_suppress: rdata=%h err=%b, required %h err=0", rd, e, mem_m[4]);
        end
        last_rd = mem_m[4];
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_random();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        test_align();
`endif
        test_zero_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
